// File: rtl/mwadd_pkg.sv
// Shared definitions for the multi-word add sequencer: word width, FSM states
// and a word-slicing helper.
package mwadd_pkg;

    localparam int WORD_W    = 16;
    localparam int MAX_WORDS = 16;
    localparam int MAX_W     = WORD_W * MAX_WORDS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Callers zero-extend their operand to MAX_W so one helper serves any NUM_WORDS.
    function automatic logic [WORD_W-1:0] word_at(input logic [MAX_W-1:0] vec, input int idx);
        return vec[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake bundle for multiword_add_sequencer.
// The subtract signal exists only when MWADD_SUB_EN is defined.
interface multiword_add_sequencer_if
    import mwadd_pkg::*;
#(
    parameter int NUM_WORDS = 4
);
    localparam int TOTAL_W = WORD_W * NUM_WORDS;

    logic               inValid;
    logic               inReady;
    logic [TOTAL_W-1:0] opA;
    logic [TOTAL_W-1:0] opB;
    logic               carryIn;
    logic               outValid;
    logic               outReady;
    logic [TOTAL_W-1:0] sum;
    logic               carryOut;
    logic               busy;

`ifdef MWADD_SUB_EN
    logic               subtract;

    modport master (
        output inValid, opA, opB, carryIn, subtract, outReady,
        input  inReady, outValid, sum, carryOut, busy
    );
    modport slave (
        input  inValid, opA, opB, carryIn, subtract, outReady,
        output inReady, outValid, sum, carryOut, busy
    );
`else
    modport master (
        output inValid, opA, opB, carryIn, outReady,
        input  inReady, outValid, sum, carryOut, busy
    );
    modport slave (
        input  inValid, opA, opB, carryIn, outReady,
        output inReady, outValid, sum, carryOut, busy
    );
`endif

endinterface

// File: rtl/FullAdderX16.sv
// 16-bit adder with carry in/out; the single shared datapath of the sequencer.
module FullAdderX16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out
);

    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two NUM_WORDS x 16-bit operands one word per cycle through a shared adder.
// Define MWADD_SUB_EN to add a subtract input (A - B, carryOut=1 means no borrow).
module multiword_add_sequencer
    import mwadd_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic                      clk,
    input  logic                      resetN,
    multiword_add_sequencer_if.slave  bus
);

    localparam int               TOTAL_W  = WORD_W * NUM_WORDS;
    localparam int               IDX_W    = $clog2(NUM_WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry_q;
    logic [TOTAL_W-1:0] a_q;
    logic [TOTAL_W-1:0] b_q;
    logic [TOTAL_W-1:0] sum_q;
    logic               carry_out_q;
    logic               out_valid_q;

    logic [TOTAL_W-1:0] b_in;
    logic               carry_init;
    logic [WORD_W-1:0]  word_a;
    logic [WORD_W-1:0]  word_b;
    logic [WORD_W-1:0]  word_sum;
    logic               word_carry;

`ifdef MWADD_SUB_EN
    // Two's-complement subtract: invert B once at capture and seed the carry with 1.
    assign b_in       = bus.subtract ? ~bus.opB : bus.opB;
    assign carry_init = bus.subtract | bus.carryIn;
`else
    assign b_in       = bus.opB;
    assign carry_init = bus.carryIn;
`endif

    assign word_a = word_at(MAX_W'(a_q), int'(idx));
    assign word_b = word_at(MAX_W'(b_q), int'(idx));

    FullAdderX16 u_adder (
        .a         (word_a),
        .b         (word_b),
        .carry_in  (carry_q),
        .sum       (word_sum),
        .carry_out (word_carry)
    );

    // NOTE: all state is updated with non-blocking assignments so every branch
    // sees the pre-edge values of idx, carry_q and state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            idx         <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.inValid) begin
                        a_q     <= bus.opA;
                        b_q     <= b_in;
                        carry_q <= carry_init;
                        idx     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int w = 0; w < NUM_WORDS; w++) begin
                        if (idx == IDX_W'(w)) sum_q[w*WORD_W +: WORD_W] <= word_sum;
                    end
                    carry_q <= word_carry;
                    idx     <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        carry_out_q <= word_carry;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.outReady) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.inReady  = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.outValid = out_valid_q;
    assign bus.sum      = sum_q;
    assign bus.carryOut = carry_out_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed, table-driven bench for multiword_add_sequencer at NUM_WORDS=4;
// also covers back-pressure and mid-run reset, plus subtract when MWADD_SUB_EN is set.
module tb_multiword_add_sequencer;

    localparam int NW = 4;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] exp_sum;
        logic        exp_cout;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    multiword_add_sequencer_if #(.NUM_WORDS(NW)) bus ();

    multiword_add_sequencer #(.NUM_WORDS(NW)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sub);
        bus.opA     = a;
        bus.opB     = b;
        bus.carryIn = cin;
`ifdef MWADD_SUB_EN
        bus.subtract = sub;
`else
        if (sub) $display("note: subtract vector applied without MWADD_SUB_EN");
`endif
        bus.inValid = 1'b1;
    endtask

    // Returns the number of edges until outValid, bounded.
    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!bus.outValid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Full transaction with outReady held high: accept, latency, result, consume.
    task automatic run_op(input vec_t v);
        int lat;
        int guard = 0;
        while (!bus.inReady && guard < 20) begin
            tick();
            guard++;
        end
        check({v.name, " inReady before accept"}, 64'(bus.inReady), 64'd1);
        drive_op(v.a, v.b, v.cin, v.sub);
        tick();
        bus.inValid = 1'b0;
        bus.opA     = ~v.a;
        bus.opB     = ~v.b;
        bus.carryIn = ~v.cin;
        check({v.name, " busy after accept"}, 64'(bus.busy), 64'd1);
        wait_out_valid(lat);
        check({v.name, " latency"}, 64'(lat), 64'(NW));
        check({v.name, " sum"}, bus.sum, v.exp_sum);
        check({v.name, " carryOut"}, 64'(bus.carryOut), 64'(v.exp_cout));
        check({v.name, " inReady in DONE"}, 64'(bus.inReady), 64'd0);
        tick();
        check({v.name, " outValid one cycle"}, 64'(bus.outValid), 64'd0);
        check({v.name, " idle after consume"}, 64'(bus.inReady), 64'd1);
    endtask

    initial begin
        int lat;
        vec_t v;

        vecs.push_back('{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, "zero_cin"});
        vecs.push_back('{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, "word0_carry"});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, "full_ripple"});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, "top_overflow"});
        vecs.push_back('{64'hFFFF_0000_FFFF_0000, 64'h0001_FFFF_0001_FFFF, 1'b0, 1'b0, 64'h0001_0000_0000_FFFF, 1'b1, "mixed_chain"});
        vecs.push_back('{64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0, 1'b0, 64'h1234_5678_9ABC_DEF1, 1'b0, "plain"});
`ifdef MWADD_SUB_EN
        vecs.push_back('{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "sub_borrow"});
        vecs.push_back('{64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, "sub_no_borrow"});
`endif

        resetN       = 1'b0;
        bus.inValid  = 1'b0;
        bus.opA      = '0;
        bus.opB      = '0;
        bus.carryIn  = 1'b0;
        bus.outReady = 1'b1;
`ifdef MWADD_SUB_EN
        bus.subtract = 1'b0;
`endif
        #12;
        check("reset inReady", 64'(bus.inReady), 64'd1);
        check("reset outValid", 64'(bus.outValid), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset sum", bus.sum, 64'd0);
        check("reset carryOut", 64'(bus.carryOut), 64'd0);
        resetN = 1'b1;
        tick();

        foreach (vecs[i]) run_op(vecs[i]);

        // Back-pressure: result held while a new op waits on inValid.
        bus.outReady = 1'b0;
        drive_op(64'h1, 64'h2, 1'b0, 1'b0);
        tick();
        drive_op(64'hA, 64'h14, 1'b0, 1'b0);
        wait_out_valid(lat);
        check("bp latency", 64'(lat), 64'(NW));
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp sum stable", bus.sum, 64'h3);
            check("bp outValid stable", 64'(bus.outValid), 64'd1);
            check("bp carryOut stable", 64'(bus.carryOut), 64'd0);
            check("bp inReady low", 64'(bus.inReady), 64'd0);
        end
        bus.outReady = 1'b1;
        tick();
        check("bp consumed outValid", 64'(bus.outValid), 64'd0);
        check("bp consumed idle", 64'(bus.busy), 64'd0);
        tick();
        check("bp next accepted", 64'(bus.busy), 64'd1);
        bus.inValid = 1'b0;
        wait_out_valid(lat);
        check("bp next latency", 64'(lat), 64'(NW));
        check("bp next sum", bus.sum, 64'h1E);
        tick();

        // Reset two cycles into RUN abandons the op.
        drive_op(64'h1234_5678_9ABC_DEF0, 64'h1, 1'b0, 1'b0);
        tick();
        bus.inValid = 1'b0;
        tick();
        tick();
        #2;
        resetN = 1'b0;
        #1;
        check("midrun reset inReady", 64'(bus.inReady), 64'd1);
        check("midrun reset outValid", 64'(bus.outValid), 64'd0);
        check("midrun reset busy", 64'(bus.busy), 64'd0);
        check("midrun reset sum", bus.sum, 64'd0);
        check("midrun reset carryOut", 64'(bus.carryOut), 64'd0);
        #3;
        resetN = 1'b1;
        v = '{64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, "after_reset"};
        run_op(v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
